ts_reg_bank: RTL and testbench
==============================

# ts_reg_bank

Parametrised bank of CPU-accessible test (scratch) registers for register-path bring-up and liveness checks. Occupies DEPTH consecutive word addresses starting at a runtime base address. Each entry stores either the inverted or the direct write data, selected at elaboration. Reads are registered with a valid strobe, and an optional saturating write-hit counter sits at offset DEPTH.

## Interface
Parameters:
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 32, data width of every entry and of the counter; legal range 8..64.
- DEPTH, 4, number of test entries; legal range 1..256; DEPTH+1 must not exceed 2^ADDR_WIDTH.
- INV_MODE, 1, 1 = entry stores ~cpu_data_in, 0 = entry stores cpu_data_in.

Ports:
- clks  input  1  single clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_data_in  input  DATA_WIDTH  write data.
- cpu_addr  input  ADDR_WIDTH  access address.
- cpu_wr  input  1  write strobe, one cycle per write.
- cpu_rd  input  1  read strobe, one cycle per read.
- its_addr  input  ADDR_WIDTH  bank base address; quasi-static.
- cpu_data_out  output  DATA_WIDTH  registered read data.
- cpu_rd_vld  output  1  one-cycle pulse marking a valid read response.

## Operation
- Offset: `off = (cpu_addr - its_addr) mod 2^ADDR_WIDTH`.
  - Entry hit: `off < DEPTH`.
  - Counter hit: `off == DEPTH`, only when the macro is defined.
  - Addresses past the top of the map wrap to zero and still hit.
- Write, when cpu_wr and entry hit: `entry[off]` is loaded with ~cpu_data_in (INV_MODE=1) or cpu_data_in (INV_MODE=0). Writes that hit nothing are ignored.
- Read, when cpu_rd:
  - Hit: the next cycle has cpu_rd_vld=1 and cpu_data_out = the addressed value as it was before any same-cycle write.
  - Miss: the next cycle has cpu_rd_vld=0 and cpu_data_out=0.
- cpu_data_out is 0 in every cycle that cpu_rd_vld is 0.
- Simultaneous cpu_wr and cpu_rd to the same entry: the read returns the old value, and the write takes effect.
- Back-to-back reads on consecutive cycles give consecutive cpu_rd_vld pulses. No stalls and no backpressure.

## Timing
- Reset (reset_n low, asynchronous, any time, including mid-access): every entry, the counter, cpu_data_out and cpu_rd_vld go to 0 immediately.
  - A read whose strobe was sampled before reset and whose response falls during or after reset produces no response.
- Release: the first write or read is accepted on the first rising edge with reset_n high.
- Write latency: the entry is updated at the clock edge that samples cpu_wr. A read issued the next cycle sees the new value.
- Read latency: exactly 1 cycle, from the edge sampling cpu_rd to cpu_rd_vld high.
- Counter:
  - Increments by 1 on each entry write-hit.
  - Saturates at all-ones and never wraps.
  - A write to the counter offset clears it to 0; the write data is ignored.
  - A clear has priority over an increment in the same cycle, although a single strobe cannot produce both.

## Configuration
- Macro TS_REG_BANK_WR_CNT_EN.
- Defined: the write-hit counter exists at offset DEPTH with the read, clear and saturation behaviour above. The bank spans DEPTH+1 words.
- Undefined: there is no counter flop. Offset DEPTH is a miss, so a read there gives cpu_rd_vld=0 and data 0, and a write there is ignored. The bank spans DEPTH words.

## Test plan
- Reset, then read offsets 0..DEPTH-1 (DEPTH=4, INV_MODE=1, its_addr=0x0100) -> each read returns cpu_rd_vld=1 and data 0x00000000, one cycle after cpu_rd.
- Write 0x12345678 to 0x0102, read 0x0102 next cycle -> 0xEDCBA987. Repeat with INV_MODE=0 -> 0x12345678. Other entries remain 0.
- Same-cycle write 0xFFFF0000 and read on 0x0101 holding 0 -> read returns 0x00000000 (old value); a following read returns 0x0000FFFF.
- Read 0x0100+DEPTH+1 and 0x00FF -> cpu_rd_vld=0, data 0. With its_addr=0xFFFE and DEPTH=4, write 0x0001 -> updates entry 3.
- With macro defined: 3 entry writes, then read 0x0104 -> 3. Write to 0x0104, then read -> 0. Preload to near all-ones, keep writing -> the value holds at 0xFFFFFFFF. Without the macro, read 0x0104 -> cpu_rd_vld=0.
- Assert reset_n low between cpu_rd and its response -> no cpu_rd_vld pulse. All entries read 0 after release.

Source files
------------

// File: rtl/ts_reg_bank_if.sv
// CPU access bus for ts_reg_bank: strobes, address, write data, bank base and registered read return.
interface ts_reg_bank_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_wr;
    logic                  cpu_rd;
    logic [ADDR_WIDTH-1:0] its_addr;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic                  cpu_rd_vld;

    modport master (
        output cpu_data_in, cpu_addr, cpu_wr, cpu_rd, its_addr,
        input  cpu_data_out, cpu_rd_vld
    );

    modport slave (
        input  cpu_data_in, cpu_addr, cpu_wr, cpu_rd, its_addr,
        output cpu_data_out, cpu_rd_vld
    );
endinterface

// File: rtl/ts_reg_bank.sv
// ts_reg_bank: CPU scratch registers at a runtime base address, one-cycle registered reads.
// Define TS_REG_BANK_WR_CNT_EN to add a saturating write-hit counter at offset DEPTH.
module ts_reg_bank #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int INV_MODE   = 1
) (
    input  logic         clks,
    input  logic         reset_n,
    ts_reg_bank_if.slave bus
);
    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] L_DEPTH = ADDR_WIDTH'(DEPTH);

    if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || DEPTH < 1 || DEPTH > 256 ||
        (64'(DEPTH) + 64'd1) > (64'd1 << ADDR_WIDTH)) begin : g_param_check
        $error("ts_reg_bank: DATA_WIDTH, DEPTH or ADDR_WIDTH out of range");
    end

    logic [DATA_WIDTH-1:0] r_entry [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data_p1;
    logic                  r_rd_vld_p1;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_entry_hit;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // Modular subtraction makes a bank near the top of the map wrap through zero.
    assign w_off       = bus.cpu_addr - bus.its_addr;
    assign w_idx       = w_off[IDX_W-1:0];
    assign w_entry_hit = (w_off < L_DEPTH);
    assign w_wr_data   = (INV_MODE != 0) ? ~bus.cpu_data_in : bus.cpu_data_in;

`ifdef TS_REG_BANK_WR_CNT_EN
    logic [DATA_WIDTH-1:0] r_cnt;
    logic                  w_cnt_hit;

    function automatic logic [DATA_WIDTH-1:0] f_sat_inc(input logic [DATA_WIDTH-1:0] v);
        return (&v) ? v : v + DATA_WIDTH'(1);
    endfunction

    assign w_cnt_hit = (w_off == L_DEPTH);

    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (bus.cpu_wr && w_cnt_hit) begin
            r_cnt <= '0;
        end else if (bus.cpu_wr && w_entry_hit) begin
            r_cnt <= f_sat_inc(r_cnt);
        end
    end
`endif

    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (bus.cpu_wr && w_entry_hit) begin
            r_entry[w_idx] <= w_wr_data;
        end
    end

    // Read mux sees pre-write state, so a same-cycle write/read returns the old value.
    always_comb begin
        w_rd_hit = 1'b0;
        w_rd_val = '0;
        if (w_entry_hit) begin
            w_rd_hit = 1'b1;
            w_rd_val = r_entry[w_idx];
        end
`ifdef TS_REG_BANK_WR_CNT_EN
        else if (w_cnt_hit) begin
            w_rd_hit = 1'b1;
            w_rd_val = r_cnt;
        end
`endif
    end

    // p0 -> p1: registered read response, data forced to zero whenever not valid
    always_ff @(posedge clks or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_rd_vld_p1  <= bus.cpu_rd && w_rd_hit;
            r_rd_data_p1 <= (bus.cpu_rd && w_rd_hit) ? w_rd_val : '0;
        end
    end

    assign bus.cpu_data_out = r_rd_data_p1;
    assign bus.cpu_rd_vld   = r_rd_vld_p1;
endmodule

// File: tb/tb_ts_reg_bank.sv
// Scoreboard bench for ts_reg_bank: three instances (INV_MODE=1/32b, INV_MODE=0/32b, INV_MODE=1/8b).
// Counter expectations follow TS_REG_BANK_WR_CNT_EN.
module tb_ts_reg_bank;
`ifdef TS_REG_BANK_WR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] ed;
    } op_t;

    logic clks = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [8:0]  q_c[$];
    logic [32:0] e;
    logic [8:0]  ec;

    always #5 clks = ~clks;

    ts_reg_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) if_a ();
    ts_reg_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) if_b ();
    ts_reg_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8))  if_c ();

    ts_reg_bank #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4), .INV_MODE(1)) dut_a (
        .clks(clks), .reset_n(reset_n), .bus(if_a));
    ts_reg_bank #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4), .INV_MODE(0)) dut_b (
        .clks(clks), .reset_n(reset_n), .bus(if_b));
    ts_reg_bank #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEPTH(4), .INV_MODE(1)) dut_c (
        .clks(clks), .reset_n(reset_n), .bus(if_c));

    function automatic op_t mk(input logic wr, input logic rd, input logic [15:0] a,
                               input logic [31:0] wd, input logic ev, input logic [31:0] ed);
        op_t o;
        o.wr = wr; o.rd = rd; o.addr = a; o.wd = wd; o.ev = ev; o.ed = ed;
        return o;
    endfunction

    task automatic drive_a(input op_t op);
        if_a.cpu_wr = op.wr; if_a.cpu_rd = op.rd; if_a.cpu_addr = op.addr; if_a.cpu_data_in = op.wd;
        q_a.push_back({op.ev, op.ed});
        @(posedge clks); #1;
    endtask

    task automatic drive_b(input op_t op);
        if_b.cpu_wr = op.wr; if_b.cpu_rd = op.rd; if_b.cpu_addr = op.addr; if_b.cpu_data_in = op.wd;
        q_b.push_back({op.ev, op.ed});
        @(posedge clks); #1;
    endtask

    task automatic drive_c(input op_t op);
        if_c.cpu_wr = op.wr; if_c.cpu_rd = op.rd; if_c.cpu_addr = op.addr; if_c.cpu_data_in = op.wd[7:0];
        q_c.push_back({op.ev, op.ed[7:0]});
        @(posedge clks); #1;
    endtask

    task automatic test_reset();
        op_t ops[$];
        #8;
        n_checks++;
        if ({if_a.cpu_rd_vld, if_a.cpu_data_out, if_b.cpu_rd_vld, if_b.cpu_data_out,
             if_c.cpu_rd_vld, if_c.cpu_data_out} !== 75'd0) begin
            n_errors++;
            $display("FAIL reset_state: got a=%0b/%h b=%0b/%h c=%0b/%h, want all zero",
                     if_a.cpu_rd_vld, if_a.cpu_data_out, if_b.cpu_rd_vld, if_b.cpu_data_out,
                     if_c.cpu_rd_vld, if_c.cpu_data_out);
        end
        #4 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) ops.push_back(mk(1'b0, 1'b1, 16'h0100 + 16'(i), 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL reset_read[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_write_read();
        op_t ops[$];
        op_t opb[$];
        ops.push_back(mk(1'b1, 1'b0, 16'h0102, 32'h12345678, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0102, 32'h0, 1'b1, 32'hEDCBA987));
        ops.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0103, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0102, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL write_read_inv[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
        opb.push_back(mk(1'b1, 1'b0, 16'h0102, 32'h12345678, 1'b0, 32'h0));
        opb.push_back(mk(1'b0, 1'b1, 16'h0102, 32'h0, 1'b1, 32'h12345678));
        opb.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h0, 1'b1, 32'h0));
        opb.push_back(mk(1'b0, 1'b1, 16'h0103, 32'h0, 1'b1, 32'h0));
        opb.push_back(mk(1'b0, 1'b0, 16'h0102, 32'h0, 1'b0, 32'h0));
        foreach (opb[i]) begin
            drive_b(opb[i]);
            e = q_b.pop_front(); n_checks++;
            if ({if_b.cpu_rd_vld, if_b.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL write_read_direct[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_b.cpu_rd_vld, if_b.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_same_cycle();
        op_t ops[$];
        ops.push_back(mk(1'b1, 1'b1, 16'h0101, 32'hFFFF0000, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'h0000FFFF));
        ops.push_back(mk(1'b0, 1'b0, 16'h0101, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL same_cycle[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        ops.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'h0000FFFF));
        ops.push_back(mk(1'b0, 1'b1, 16'h0102, 32'h0, 1'b1, 32'hEDCBA987));
        ops.push_back(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'h0000FFFF));
        ops.push_back(mk(1'b0, 1'b1, 16'h0103, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0103, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_miss_wrap();
        op_t ops[$];
        ops.push_back(mk(1'b0, 1'b1, 16'h0105, 32'h0, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h00FF, 32'h0, 1'b0, 32'h0));
        ops.push_back(mk(1'b1, 1'b0, 16'h00FF, 32'hAAAA5555, 1'b0, 32'h0));
        ops.push_back(mk(1'b1, 1'b0, 16'h0105, 32'hAAAA5555, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0103, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL miss[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
        if_a.its_addr = 16'hFFFE;
        ops.delete();
        ops.push_back(mk(1'b1, 1'b0, 16'h0001, 32'h000000FF, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0001, 32'h0, 1'b1, 32'hFFFFFF00));
        ops.push_back(mk(1'b0, 1'b1, 16'hFFFE, 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'hFFFF, 32'h0, 1'b1, 32'h0000FFFF));
        ops.push_back(mk(1'b0, 1'b1, 16'hFFFD, 32'h0, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0001, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL wrap[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
        if_a.its_addr = 16'h0100;
        drive_a(mk(1'b0, 1'b1, 16'h0103, 32'h0, 1'b1, 32'hFFFFFF00));
        e = q_a.pop_front(); n_checks++;
        if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
            n_errors++;
            $display("FAIL wrap_entry3: got vld=%0b data=%h, want vld=%0b data=%h",
                     if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
        end
    endtask

    task automatic test_counter();
        op_t ops[$];
        ops.push_back(mk(1'b1, 1'b0, 16'h0104, 32'hDEADBEEF, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) ops.push_back(mk(1'b1, 1'b0, 16'h0100, 32'h11111111, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, CNT_EN ? 32'd3 : 32'd0));
        ops.push_back(mk(1'b1, 1'b0, 16'h0104, 32'hFFFFFFFF, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0100, 32'h0, 1'b1, 32'hEEEEEEEE));
        ops.push_back(mk(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL counter[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_saturation();
        op_t ops[$];
        ops.push_back(mk(1'b1, 1'b0, 16'h0104, 32'h5A, 1'b0, 32'h0));
        for (int i = 0; i < 254; i++) ops.push_back(mk(1'b1, 1'b0, 16'h0100 + 16'(i % 4), 32'(i), 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, CNT_EN ? 32'hFE : 32'h0));
        ops.push_back(mk(1'b1, 1'b0, 16'h0101, 32'h3C, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, CNT_EN ? 32'hFF : 32'h0));
        for (int i = 0; i < 3; i++) ops.push_back(mk(1'b1, 1'b0, 16'h0102, 32'h0F, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, CNT_EN ? 32'hFF : 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'hC3));
        ops.push_back(mk(1'b1, 1'b0, 16'h0104, 32'h77, 1'b0, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0104, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_c(ops[i]);
            ec = q_c.pop_front(); n_checks++;
            if ({if_c.cpu_rd_vld, if_c.cpu_data_out} !== ec) begin
                n_errors++;
                $display("FAIL saturation[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_c.cpu_rd_vld, if_c.cpu_data_out, ec[8], ec[7:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        op_t ops[$];
        if_a.cpu_wr = 1'b0; if_a.cpu_rd = 1'b1; if_a.cpu_addr = 16'h0102;
        q_a.push_back({1'b0, 32'h0});
        #2 reset_n = 1'b0;
        @(posedge clks); #1;
        if_a.cpu_rd = 1'b0;
        e = q_a.pop_front(); n_checks++;
        if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
            n_errors++;
            $display("FAIL reset_before_resp: got vld=%0b data=%h, want vld=%0b data=%h",
                     if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
        end
        #2 reset_n = 1'b1;
        drive_a(mk(1'b0, 1'b1, 16'h0101, 32'h0, 1'b1, 32'h0));
        e = q_a.pop_front(); n_checks++;
        if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
            n_errors++;
            $display("FAIL first_read_after_release: got vld=%0b data=%h, want vld=%0b data=%h",
                     if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
        end
        if_a.cpu_rd = 1'b0;
        q_a.push_back({1'b0, 32'h0});
        #2 reset_n = 1'b0;
        #1;
        e = q_a.pop_front(); n_checks++;
        if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
            n_errors++;
            $display("FAIL reset_during_resp: got vld=%0b data=%h, want vld=%0b data=%h",
                     if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) ops.push_back(mk(1'b0, 1'b1, 16'h0100 + 16'(i), 32'h0, 1'b1, 32'h0));
        ops.push_back(mk(1'b0, 1'b1, 16'h0104, 32'h0, CNT_EN, 32'h0));
        ops.push_back(mk(1'b0, 1'b0, 16'h0100, 32'h0, 1'b0, 32'h0));
        foreach (ops[i]) begin
            drive_a(ops[i]);
            e = q_a.pop_front(); n_checks++;
            if ({if_a.cpu_rd_vld, if_a.cpu_data_out} !== e) begin
                n_errors++;
                $display("FAIL post_reset_read[%0d]: got vld=%0b data=%h, want vld=%0b data=%h",
                         i, if_a.cpu_rd_vld, if_a.cpu_data_out, e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        if_a.cpu_wr = 1'b0; if_a.cpu_rd = 1'b0; if_a.cpu_addr = '0; if_a.cpu_data_in = '0; if_a.its_addr = 16'h0100;
        if_b.cpu_wr = 1'b0; if_b.cpu_rd = 1'b0; if_b.cpu_addr = '0; if_b.cpu_data_in = '0; if_b.its_addr = 16'h0100;
        if_c.cpu_wr = 1'b0; if_c.cpu_rd = 1'b0; if_c.cpu_addr = '0; if_c.cpu_data_in = '0; if_c.its_addr = 16'h0100;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_miss_wrap();
        test_counter();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end
endmodule
